// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the bit-serial link (transmit and receive ends).
package piso_serializer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Mod-WIDTH bit counter with synchronous clear, enable and terminal count.
module piso_serializer_bit_counter
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int CW = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          clear,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    assign tc = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter, MSB first, with Frame and Done.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             SReset,
    input  logic [WIDTH-1:0] Din,
    input  logic             Load,
    output logic             Ready,
    output logic             Dout,
    output logic             Frame,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_nx;
    logic [CW-1:0]    cnt;
    logic             tc;
    logic             accept;

    piso_serializer_bit_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk   (Clk),
        .srst  (SReset),
        .clear (accept),
        .en    (state == SHIFT),
        .cnt   (cnt),
        .tc    (tc)
    );

    // Ready is allowed a combinational path from SReset only.
    assign Ready  = ~SReset & ((state == IDLE) | tc);
    assign accept = Load & Ready;

    assign Frame = (state == SHIFT);
    assign Dout  = Frame & shift_reg[WIDTH-1];
    assign Done  = Frame & tc;

    always_comb begin
        state_nx = state;
        shift_nx = shift_reg;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    shift_nx = Din;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                shift_nx = shift_reg << 1;
                if (tc) begin
                    if (accept) begin
                        shift_nx = Din;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (SReset) begin
            state     <= IDLE;
            shift_reg <= '0;
        end else begin
            state     <= state_nx;
            shift_reg <= shift_nx;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: accepted words become queued bits, checked as they appear.
module tb_piso_serializer;

    localparam int WIDTH = 8;

    typedef struct {
        logic b;
        logic d;
    } exp_t;

    logic             Clk = 1'b0;
    logic             SReset = 1'b1;
    logic [WIDTH-1:0] Din = '0;
    logic             Load = 1'b0;
    logic             Ready;
    logic             Dout;
    logic             Frame;
    logic             Done;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   started = 1'b0;

    piso_serializer #(.WIDTH(WIDTH)) dut (
        .Clk    (Clk),
        .SReset (SReset),
        .Din    (Din),
        .Load   (Load),
        .Ready  (Ready),
        .Dout   (Dout),
        .Frame  (Frame),
        .Done   (Done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    // Model: a word can be taken only once every queued bit has been sent.
    task automatic step(input logic ld, input logic [WIDTH-1:0] d,
                        input logic rst);
        bit acc;
        exp_t e;
        Load   = ld;
        Din    = d;
        SReset = rst;
        @(posedge Clk);
        acc = ld && !rst && (q.size() == 0);
        if (rst) begin
            q.delete();
        end else if (acc) begin
            for (int k = 0; k < WIDTH; k++) begin
                e.b = d[WIDTH-1-k];
                e.d = (k == WIDTH - 1);
                q.push_back(e);
            end
        end
        started = 1'b1;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, $urandom, 1'b0);
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (started) begin
            chk("ready", Ready, !SReset && (q.size() <= 1));
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("frame", Frame, 1'b1);
                chk("dout", Dout, e.b);
                chk("done", Done, e.d);
            end else begin
                chk("frame_idle", Frame, 1'b0);
                chk("dout_idle", Dout, 1'b0);
                chk("done_idle", Done, 1'b0);
            end
        end
    end

    initial begin
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        idle(10);
        // single word
        step(1'b1, 8'hA5, 1'b0);
        idle(10);
        // back-to-back, second load in the Done cycle
        step(1'b1, 8'hA5, 1'b0);
        idle(7);
        step(1'b1, 8'h3C, 1'b0);
        idle(10);
        // loads while busy are ignored
        step(1'b1, 8'h00, 1'b0);
        step(1'b0, 8'hFF, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 8'hFF, 1'b0);
        idle(6);
        // reset mid-word, then a fresh word
        step(1'b1, 8'hFF, 1'b0);
        idle(2);
        step(1'b0, '0, 1'b1);
        idle(1);
        step(1'b1, 8'h81, 1'b0);
        idle(10);
        // load coinciding with reset is dropped
        step(1'b1, 8'h55, 1'b1);
        idle(12);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 2) != 0), $urandom,
                 ($urandom_range(0, 49) == 0));
        end
        idle(12);
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
